// File: rtl/lcd_pkg.sv
// Shared constants, state type and character sanitiser for the serial-LCD
// frame writer (SparkFun 16x2 command set).
package lcd_pkg;

    localparam logic [7:0] LCD_CMD_PREFIX     = 8'hFE;
    localparam logic [7:0] LCD_SPECIAL_PREFIX = 8'h7C;
    localparam logic [7:0] LCD_CMD_CLEAR      = 8'h01;
    localparam logic [7:0] LCD_ADDR_LINE1     = 8'h80;
    localparam logic [7:0] LCD_ADDR_LINE2     = 8'hC0;
    localparam logic [7:0] LCD_SUB_CHAR       = 8'h20;
    localparam int         LCD_COLS           = 16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR_PREFIX,
        S_CLR_CMD,
        S_CLR_WAIT,
        S_L1_PREFIX,
        S_L1_ADDR,
        S_L1_CHARS,
        S_L2_PREFIX,
        S_L2_ADDR,
        S_L2_CHARS,
        S_DONE
    } lcd_state_e;

    // Text bytes that look like command prefixes would hijack the display.
    function automatic logic [7:0] lcd_sanitise(input logic [7:0] c);
        return ((c == LCD_CMD_PREFIX) || (c == LCD_SPECIAL_PREFIX)) ? LCD_SUB_CHAR : c;
    endfunction

endpackage

// File: rtl/lcd_frame_writer.sv
// Pushes a full clear + two-line SparkFun serial-LCD byte stream into the TX
// FIFO on a start pulse; the UART drains the FIFO independently.
module lcd_frame_writer
    import lcd_pkg::*;
#(
    parameter int unsigned CLEAR_EN   = 1,
    parameter int unsigned CLEAR_WAIT = 40
) (
    input  logic         TX_CLK,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] line1,
    input  logic [127:0] line2,
    input  logic         wrfull,
    output logic         wrreq,
    output logic [7:0]   wr_data,
    output logic         busy,
    output logic         done
);

    lcd_state_e   state_q, state_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [3:0]   idx_q, idx_d;
    logic [127:0] l1_q, l1_d;
    logic [127:0] l2_q, l2_d;
    logic         emit;
    logic [6:0]   col_lsb;

    // Column 0 lives in the top byte, so index 0 maps to bit 120.
    assign col_lsb = {4'(LCD_COLS - 1) - idx_q, 3'b000};

    always_comb begin
        emit    = 1'b0;
        wr_data = 8'h00;
        case (state_q)
            S_CLR_PREFIX: begin emit = 1'b1; wr_data = LCD_CMD_PREFIX; end
            S_CLR_CMD:    begin emit = 1'b1; wr_data = LCD_CMD_CLEAR;  end
            S_L1_PREFIX:  begin emit = 1'b1; wr_data = LCD_CMD_PREFIX; end
            S_L1_ADDR:    begin emit = 1'b1; wr_data = LCD_ADDR_LINE1; end
            S_L1_CHARS:   begin emit = 1'b1; wr_data = lcd_sanitise(l1_q[col_lsb +: 8]); end
            S_L2_PREFIX:  begin emit = 1'b1; wr_data = LCD_CMD_PREFIX; end
            S_L2_ADDR:    begin emit = 1'b1; wr_data = LCD_ADDR_LINE2; end
            S_L2_CHARS:   begin emit = 1'b1; wr_data = lcd_sanitise(l2_q[col_lsb +: 8]); end
            default:      begin emit = 1'b0; wr_data = 8'h00; end
        endcase
        wrreq = emit && !wrfull && !rst;
        busy  = (state_q != S_IDLE) && !rst;
        done  = (state_q == S_DONE) && !rst;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        l1_d    = l1_q;
        l2_d    = l2_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    l1_d    = line1;
                    l2_d    = line2;
                    state_d = (CLEAR_EN != 0) ? S_CLR_PREFIX : S_L1_PREFIX;
                end
            end
            S_CLR_PREFIX: if (wrreq) state_d = S_CLR_CMD;
            S_CLR_CMD: begin
                if (wrreq) begin
                    state_d = S_CLR_WAIT;
                    cnt_d   = 16'd0;
                end
            end
            S_CLR_WAIT: begin
                if (cnt_q == 16'(CLEAR_WAIT - 1)) begin
                    state_d = S_L1_PREFIX;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_L1_PREFIX: if (wrreq) state_d = S_L1_ADDR;
            S_L1_ADDR:   if (wrreq) state_d = S_L1_CHARS;
            S_L1_CHARS: begin
                if (wrreq) begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'(LCD_COLS - 1)) state_d = S_L2_PREFIX;
                end
            end
            S_L2_PREFIX: if (wrreq) state_d = S_L2_ADDR;
            S_L2_ADDR:   if (wrreq) state_d = S_L2_CHARS;
            S_L2_CHARS: begin
                if (wrreq) begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'(LCD_COLS - 1)) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Reset overrides every transition, including a coincident start.
        if (rst) begin
            state_d = S_IDLE;
            cnt_d   = 16'd0;
            idx_d   = 4'd0;
            l1_d    = '0;
            l2_d    = '0;
        end
    end

    always_ff @(posedge TX_CLK) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        idx_q   <= idx_d;
        l1_q    <= l1_d;
        l2_q    <= l2_d;
    end

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Self-checking bench: captured FIFO writes compared with a byte-list model of
// the LCD frame, for both the clearing and non-clearing build.
module tb_lcd_frame_writer;

    logic         TX_CLK = 1'b0;
    logic         rst, start, wrfull;
    logic [127:0] line1, line2;
    logic         wrreq_a, busy_a, done_a, wrreq_b, busy_b, done_b;
    logic [7:0]   data_a, data_b;
    logic         sel;
    logic         m_wrreq, m_busy, m_done;
    logic [7:0]   m_data;

    int total = 0;
    int passed = 0;
    int cyc = 0;
    logic [7:0] cap[$];
    int         capcyc[$];
    logic [7:0] exp_q[$];

    always #5 TX_CLK = ~TX_CLK;

    lcd_frame_writer #(.CLEAR_EN(1), .CLEAR_WAIT(40)) dut_a (
        .TX_CLK(TX_CLK), .rst(rst), .start(start), .line1(line1), .line2(line2),
        .wrfull(wrfull), .wrreq(wrreq_a), .wr_data(data_a), .busy(busy_a), .done(done_a));

    lcd_frame_writer #(.CLEAR_EN(0), .CLEAR_WAIT(40)) dut_b (
        .TX_CLK(TX_CLK), .rst(rst), .start(start), .line1(line1), .line2(line2),
        .wrfull(wrfull), .wrreq(wrreq_b), .wr_data(data_b), .busy(busy_b), .done(done_b));

    assign m_wrreq = sel ? wrreq_b : wrreq_a;
    assign m_data  = sel ? data_b  : data_a;
    assign m_busy  = sel ? busy_b  : busy_a;
    assign m_done  = sel ? done_b  : done_a;

    always @(posedge TX_CLK) cyc <= cyc + 1;

    always @(negedge TX_CLK) begin
        if (m_wrreq) begin
            cap.push_back(m_data);
            capcyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge TX_CLK);
        #1;
    endtask

    function automatic logic [7:0] san(input logic [7:0] c);
        return (c == 8'hFE || c == 8'h7C) ? 8'h20 : c;
    endfunction

    // Expected frame as a plain byte list.
    function automatic void build_exp(input bit clr, input logic [127:0] a, input logic [127:0] b);
        exp_q.delete();
        if (clr) begin exp_q.push_back(8'hFE); exp_q.push_back(8'h01); end
        exp_q.push_back(8'hFE); exp_q.push_back(8'h80);
        for (int c = 0; c < 16; c++) exp_q.push_back(san(a[127 - 8*c -: 8]));
        exp_q.push_back(8'hFE); exp_q.push_back(8'hC0);
        for (int c = 0; c < 16; c++) exp_q.push_back(san(b[127 - 8*c -: 8]));
    endfunction

    function automatic logic [127:0] rand_line(input int sp_pct);
        logic [127:0] l;
        int r;
        l = '0;
        for (int c = 0; c < 16; c++) begin
            r = int'($urandom_range(99));
            l[127 - 8*c -: 8] = (r < sp_pct) ? (r[0] ? 8'hFE : 8'h7C) : 8'($urandom_range(255));
        end
        return l;
    endfunction

    // mode: 0 plain, 1 directed backpressure at L1 index 3, 2 reset at L2 index 8, 3 start/line poke
    task automatic run_frame(input logic [127:0] a, input logic [127:0] b, input int bp_pct, input int mode);
        int base, st_cyc, n, done_stamp, pre;
        bit clr, seen_done, hold_done, poked;
        clr = (sel == 1'b0);
        pre = clr ? 2 : 0;
        build_exp(clr, a, b);
        base = cap.size();
        wrfull = 1'b0;
        line1 = a; line2 = b; start = 1'b1;
        st_cyc = cyc;
        tick();
        start = 1'b0;
        seen_done = 0; hold_done = 0; poked = 0; n = 0; done_stamp = 0;
        while (!seen_done && n < 400) begin
            n++;
            wrfull = (int'($urandom_range(99)) < bp_pct);
            start = 1'b0;
            if (mode == 1 && !hold_done && cap.size() - base == pre + 5) begin
                hold_done = 1;
                wrfull = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge TX_CLK);
                    chk($sformatf("bp_hold%0d", k), m_wrreq, 1'b0);
                    tick();
                end
                wrfull = 1'b0;
            end
            if (mode == 3 && !poked && cap.size() - base == pre + 8) begin
                poked = 1;
                start = 1'b1;
                line1 = rand_line(10);
                line2 = rand_line(10);
            end
            if (mode == 2 && cap.size() - base == pre + 28) begin
                rst = 1'b1;
                #1;
                chk("rst_wrreq", m_wrreq, 1'b0);
                chk("rst_busy_same", m_busy, 1'b0);
                tick();
                rst = 1'b0;
                wrfull = 1'b0;
                #1;
                chk("rst_idle_busy", m_busy, 1'b0);
                chk("rst_idle_done", m_done, 1'b0);
                chk("rst_partial_len", cap.size() - base, pre + 28);
                for (int i = 0; i < pre + 28 && base + i < cap.size(); i++)
                    chk($sformatf("rst_byte%0d", i), cap[base + i], exp_q[i]);
                repeat (60) tick();
                return;
            end
            @(negedge TX_CLK);
            if (m_done) begin seen_done = 1; done_stamp = cyc; end
            tick();
        end
        start = 1'b0;
        wrfull = 1'b0;
        chk("done_seen", seen_done, 1'b1);
        @(negedge TX_CLK);
        chk("done_one_cycle", m_done, 1'b0);
        chk("busy_after", m_busy, 1'b0);
        chk("frame_len", cap.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < cap.size(); i++)
            chk($sformatf("byte%0d", i), cap[base + i], exp_q[i]);
        if (cap.size() > base) begin
            chk("done_after_last", done_stamp, capcyc[capcyc.size() - 1] + 1);
            if (bp_pct == 0 && mode != 1 && cap.size() - base > 2) begin
                chk("first_latency", capcyc[base], st_cyc + 1);
                chk("wait_gap", capcyc[base + 2] - capcyc[base + 1] - 1, clr ? 40 : 0);
            end
        end
        repeat (60) tick();
    endtask

    initial begin
        logic [127:0] ha, hb, sa;
        sel = 1'b0; rst = 1'b1; start = 1'b1; wrfull = 1'b0;
        line1 = "HELLO WORLD     "; line2 = "SPARKFUN LCD 16X";
        tick();
        chk("reset_wrreq", m_wrreq, 1'b0);
        chk("reset_busy", m_busy, 1'b0);
        chk("reset_done", m_done, 1'b0);
        tick();
        rst = 1'b0; start = 1'b0;
        #1;
        chk("start_during_rst_ignored", m_busy, 1'b0);
        tick();
        chk("idle_busy", busy_b, 1'b0);

        ha = "HELLO WORLD     ";
        hb = "SPARKFUN LCD 16X";
        run_frame(ha, hb, 0, 0);
        run_frame(ha, hb, 0, 1);
        sa = rand_line(0);
        sa[127:120] = 8'hFE;
        sa[71:64]   = 8'h7C;
        run_frame(ha, sa, 0, 0);
        run_frame(rand_line(5), rand_line(5), 0, 3);
        run_frame(rand_line(5), rand_line(5), 0, 2);
        run_frame(rand_line(5), rand_line(5), 0, 0);
        for (int f = 0; f < 3; f++) run_frame(rand_line(30), rand_line(30), 30, 0);

        sel = 1'b1;
        run_frame(ha, hb, 0, 0);
        run_frame(rand_line(30), rand_line(30), 25, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
